uart_frame_tx: RTL and testbench
================================

Name: uart_frame_tx

Overview:
- Parametrised multi-byte UART transmitter: on a one-cycle `trans_go` pulse it captures a packed data word and serialises LEN bytes onto `uart_tx`.
- Generalises the fixed 5-byte sender with:
  - configurable byte count, baud divisor, parity, stop bits and inter-byte gap;
  - per-transfer length select;
  - busy/done/byte_done status.
- Sits between the packet source logic and the board TX pin.

Parameters:
- BAUD_DIV, 434, sys_clk cycles per bit (50 MHz / 115200); legal range ≥ 2.
- NUM_BYTES, 5, maximum bytes per transfer; width of data bus is 8*NUM_BYTES.
- PARITY_EN, 0, 1 inserts a parity bit after data bit 7.
- PARITY_ODD, 0, 0 = even parity, 1 = odd parity (ignored if PARITY_EN=0).
- STOP_BITS, 1, number of stop bits, 1 or 2.
- GAP_BITS, 0, extra idle-high bit times inserted between consecutive bytes (not after the last).
- LEN_W, 3, width of `len`; must satisfy 2^LEN_W > NUM_BYTES.

Ports:
- sys_clk, input, 1, system clock.
- rst_n, input, 1, asynchronous active-low reset.
- trans_go, input, 1, start request; sampled only when idle.
- data, input, 8*NUM_BYTES, packed payload; byte k = data[8k+7:8k]; byte 0 is sent first.
- len, input, LEN_W, bytes to send; 0 or values > NUM_BYTES are treated as NUM_BYTES.
- uart_tx, output, 1, serial line; idle high.
- busy, output, 1, high from the cycle after the accepted `trans_go` through the last stop bit.
- byte_done, output, 1, one-cycle pulse at the end of each byte's final stop bit.
- done, output, 1, one-cycle pulse at the end of the transfer; coincident with the last `byte_done`.

Behaviour:
- Clocking and reset:
  - Single clock `sys_clk`, all flops rising edge.
  - `rst_n` is asynchronous and active-low.
- Reset values: uart_tx=1, busy=0, byte_done=0, done=0, state=IDLE, all counters 0, shift/capture registers 0.
- Reset mid-operation: `uart_tx` returns high immediately (asynchronously) and the transfer is abandoned. No `done` is issued. After release the block sits in IDLE.
- States: IDLE, START, DATA, PARITY, STOP, GAP.
- Baud counter:
  - Counts 0..BAUD_DIV-1 and restarts on every state entry.
  - A bit ends when the counter reaches BAUD_DIV-1.
- IDLE:
  - uart_tx=1.
  - On `trans_go`=1 at edge T: capture `data` and effective length into registers, set byte index=0, enter START.
  - busy=1 and uart_tx=0 from cycle T+1.
- START: one bit time, uart_tx=0 → DATA.
- DATA:
  - 8 bit times, LSB first; bit counter 0..7.
  - After bit 7 → PARITY if PARITY_EN, else → STOP.
- PARITY: one bit time; uart_tx = XOR of the 8 data bits, XOR PARITY_ODD → STOP.
- STOP:
  - STOP_BITS bit times, uart_tx=1.
  - At the end of the final stop bit, byte_done=1 for one cycle.
  - If more bytes remain: go to GAP (if GAP_BITS>0) or straight to START, with byte index incremented.
  - If this was the last byte: done=1 (same cycle), then IDLE with busy=0 on the next cycle.
- GAP: GAP_BITS bit times, uart_tx=1 → START.
- Frame length: each byte occupies (1 + 8 + PARITY_EN + STOP_BITS) × BAUD_DIV cycles. A transfer takes LEN × that + (LEN−1) × GAP_BITS × BAUD_DIV cycles.
- Input stability:
  - `trans_go` while busy=1 is ignored; it is not queued.
  - `data` and `len` may change freely after capture.
- Back-to-back: `trans_go` asserted in the cycle `done` is high is ignored (state not yet IDLE). It is first accepted one cycle later.
- `trans_go` held high continuously: one new transfer starts each time IDLE is reached.
- `uart_tx` is a registered output; it carries no combinational path from inputs.

Test Plan:
- Defaults, data=40'h1008040201, len=0, one `trans_go` pulse → bytes 01,02,04,08,10 on the line in that order:
  - each byte is 10 bits × 434 clocks;
  - busy is high for exactly 21700 cycles;
  - 5 byte_done pulses;
  - done coincides with the 5th byte_done.
- BAUD_DIV=4, PARITY_EN=1, PARITY_ODD=0, data byte0=8'h07, len=1 → line sequence 0,1,1,1,0,0,0,0,0,1(parity),1(stop), each bit 4 cycles; done at cycle 44 after go.
- BAUD_DIV=4, STOP_BITS=2, GAP_BITS=1, len=2, bytes A5,3C → high time between byte 0's start bit and byte 1's start bit is 3 bit times (12 cycles); total busy = 2×44 + 4 = 92 cycles.
- `trans_go` pulsed again mid-transfer, and again in the `done` cycle → both ignored:
  - a pulse one cycle after `done` starts a new frame with the start bit on the following cycle.
- `rst_n` asserted during DATA bit 3 → uart_tx=1 and busy=0 with no clock edge; no done pulse; a fresh `trans_go` after release transmits correctly from byte 0.
- len=7 with NUM_BYTES=5 → exactly 5 bytes sent; len=3 → bytes 0–2 sent, data[39:24] never appear on the line.

Source files
------------

// File: rtl/uart_frame_tx_if.sv
// Handshake bundle between a packet source and the multi-byte UART transmitter.
// The source owns trans_go/data/len; the transmitter drives the line and status.
interface uart_frame_tx_if #(
  parameter int NUM_BYTES = 5,
  parameter int LEN_W     = 3
);
  logic                   trans_go;
  logic [8*NUM_BYTES-1:0] data;
  logic [LEN_W-1:0]       len;
  logic                   uart_tx;
  logic                   busy;
  logic                   byte_done;
  logic                   done;

  modport master (
    output trans_go, data, len,
    input  uart_tx, busy, byte_done, done
  );

  modport slave (
    input  trans_go, data, len,
    output uart_tx, busy, byte_done, done
  );
endinterface

// File: rtl/uart_frame_tx.sv
// Multi-byte UART transmitter: captures a packed word on trans_go and sends
// len bytes (byte 0 first) with optional parity, 1/2 stop bits and idle gaps.
module uart_frame_tx #(
  parameter int BAUD_DIV   = 434,
  parameter int NUM_BYTES  = 5,
  parameter int PARITY_EN  = 0,
  parameter int PARITY_ODD = 0,
  parameter int STOP_BITS  = 1,
  parameter int GAP_BITS   = 0,
  parameter int LEN_W      = 3
) (
  input  logic          sys_clk,
  input  logic          rst_n,
  uart_frame_tx_if.slave bus
);

  localparam int CNT_W = $clog2(BAUD_DIV);
  localparam int BIT_W = (GAP_BITS > 8) ? $clog2(GAP_BITS + 1) : 4;

  localparam logic [CNT_W-1:0] CNT_LAST  = CNT_W'(BAUD_DIV - 1);
  localparam logic [CNT_W-1:0] CNT_PRE   = CNT_W'(BAUD_DIV - 2);
  localparam logic [BIT_W-1:0] STOP_LAST = BIT_W'(STOP_BITS - 1);
  localparam logic [BIT_W-1:0] GAP_LAST  = BIT_W'((GAP_BITS > 0) ? GAP_BITS - 1 : 0);
  localparam logic [LEN_W-1:0] LEN_MAX   = LEN_W'(NUM_BYTES);

  typedef enum logic [2:0] {IDLE, START, DATA, PARITY, STOP, GAP} state_e;

  state_e                    state_q, state_d;
  logic [CNT_W-1:0]          cnt_q, cnt_d;
  logic [BIT_W-1:0]          bit_q, bit_d;
  logic [LEN_W-1:0]          byte_q, byte_d;
  logic [LEN_W-1:0]          len_q, len_d;
  logic [NUM_BYTES-1:0][7:0] data_q, data_d;
  logic                      tx_q, tx_d;
  logic                      busy_q, busy_d;
  logic                      bd_q, bd_d;
  logic                      done_q, done_d;

  logic       bit_end, stop_last, last_byte;
  logic [7:0] cur;

  assign bit_end   = (cnt_q == CNT_LAST);
  assign stop_last = (bit_q == STOP_LAST);
  assign last_byte = (byte_q == len_q - LEN_W'(1));

  always_comb begin
    state_d = state_q;
    cnt_d   = bit_end ? '0 : cnt_q + CNT_W'(1);
    bit_d   = bit_q;
    byte_d  = byte_q;
    len_d   = len_q;
    data_d  = data_q;
    bd_d    = 1'b0;
    done_d  = 1'b0;

    unique case (state_q)
      IDLE: begin
        cnt_d = '0;
        if (bus.trans_go) begin
          data_d  = bus.data;
          len_d   = (bus.len == '0 || bus.len > LEN_MAX) ? LEN_MAX : bus.len;
          byte_d  = '0;
          bit_d   = '0;
          state_d = START;
        end
      end
      START: begin
        if (bit_end) begin
          bit_d   = '0;
          state_d = DATA;
        end
      end
      DATA: begin
        if (bit_end) begin
          if (bit_q == BIT_W'(7)) begin
            bit_d   = '0;
            state_d = (PARITY_EN != 0) ? PARITY : STOP;
          end else begin
            bit_d = bit_q + BIT_W'(1);
          end
        end
      end
      PARITY: begin
        if (bit_end) begin
          bit_d   = '0;
          state_d = STOP;
        end
      end
      STOP: begin
        // Pulses are raised one cycle early so they land on the final stop cycle.
        if (stop_last && cnt_q == CNT_PRE) begin
          bd_d   = 1'b1;
          done_d = last_byte;
        end
        if (bit_end) begin
          if (!stop_last) begin
            bit_d = bit_q + BIT_W'(1);
          end else if (last_byte) begin
            state_d = IDLE;
          end else begin
            bit_d   = '0;
            byte_d  = byte_q + LEN_W'(1);
            state_d = (GAP_BITS > 0) ? GAP : START;
          end
        end
      end
      GAP: begin
        if (bit_end) begin
          if (bit_q == GAP_LAST) begin
            bit_d   = '0;
            state_d = START;
          end else begin
            bit_d = bit_q + BIT_W'(1);
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // Line level is derived from the next state so uart_tx stays a pure flop.
  always_comb begin
    cur = data_d[0];
    for (int k = 1; k < NUM_BYTES; k++)
      if (byte_d == LEN_W'(k)) cur = data_d[k];

    unique case (state_d)
      START:   tx_d = 1'b0;
      DATA:    tx_d = cur[bit_d[2:0]];
      PARITY:  tx_d = (^cur) ^ (PARITY_ODD != 0);
      default: tx_d = 1'b1;
    endcase
    busy_d = (state_d != IDLE);
  end

  always_ff @(posedge sys_clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      bit_q   <= '0;
      byte_q  <= '0;
      len_q   <= '0;
      data_q  <= '0;
      tx_q    <= 1'b1;
      busy_q  <= 1'b0;
      bd_q    <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      bit_q   <= bit_d;
      byte_q  <= byte_d;
      len_q   <= len_d;
      data_q  <= data_d;
      tx_q    <= tx_d;
      busy_q  <= busy_d;
      bd_q    <= bd_d;
      done_q  <= done_d;
    end
  end

  assign bus.uart_tx   = tx_q;
  assign bus.busy      = busy_q;
  assign bus.byte_done = bd_q;
  assign bus.done      = done_q;

endmodule

// File: tb/tb_uart_frame_tx.sv
// Directed bench for uart_frame_tx: four configurations share one clock; a line
// monitor decodes frames into a queue that is scored against expected bytes.
module tb_uart_frame_tx;

  logic sys_clk = 1'b0;
  logic rst_n   = 1'b0;
  always #5 sys_clk = ~sys_clk;

  int cyc = 0;
  always @(posedge sys_clk) cyc <= cyc + 1;

  int tests = 0;
  int fails = 0;

  logic        go_v   = 1'b0;
  logic [39:0] data_v = '0;
  logic [2:0]  len_v  = '0;
  int          sel    = 0;
  int          mbaud  = 434;
  bit          mpar   = 1'b0;

  uart_frame_tx_if #(.NUM_BYTES(5), .LEN_W(3)) i0 ();
  uart_frame_tx_if #(.NUM_BYTES(5), .LEN_W(3)) i1 ();
  uart_frame_tx_if #(.NUM_BYTES(5), .LEN_W(3)) i2 ();
  uart_frame_tx_if #(.NUM_BYTES(5), .LEN_W(3)) i3 ();

  assign i0.trans_go = go_v && (sel == 0);
  assign i1.trans_go = go_v && (sel == 1);
  assign i2.trans_go = go_v && (sel == 2);
  assign i3.trans_go = go_v && (sel == 3);
  assign i0.data = data_v;  assign i0.len = len_v;
  assign i1.data = data_v;  assign i1.len = len_v;
  assign i2.data = data_v;  assign i2.len = len_v;
  assign i3.data = data_v;  assign i3.len = len_v;

  uart_frame_tx u0 (.sys_clk(sys_clk), .rst_n(rst_n), .bus(i0.slave));
  uart_frame_tx #(.BAUD_DIV(4), .PARITY_EN(1), .PARITY_ODD(0))
    u1 (.sys_clk(sys_clk), .rst_n(rst_n), .bus(i1.slave));
  uart_frame_tx #(.BAUD_DIV(4), .STOP_BITS(2), .GAP_BITS(1))
    u2 (.sys_clk(sys_clk), .rst_n(rst_n), .bus(i2.slave));
  uart_frame_tx #(.BAUD_DIV(4))
    u3 (.sys_clk(sys_clk), .rst_n(rst_n), .bus(i3.slave));

  logic m_tx, m_busy, m_bd, m_done;
  always_comb begin
    m_tx = i0.uart_tx; m_busy = i0.busy; m_bd = i0.byte_done; m_done = i0.done;
    case (sel)
      1: begin m_tx = i1.uart_tx; m_busy = i1.busy; m_bd = i1.byte_done; m_done = i1.done; end
      2: begin m_tx = i2.uart_tx; m_busy = i2.busy; m_bd = i2.byte_done; m_done = i2.done; end
      3: begin m_tx = i3.uart_tx; m_busy = i3.busy; m_bd = i3.byte_done; m_done = i3.done; end
      default: ;
    endcase
  end

  int done3_cnt = 0;
  always @(posedge sys_clk) if (i3.done) done3_cnt <= done3_cnt + 1;

  // Scoreboard queues
  logic [7:0] exp_q[$];
  logic [7:0] rx_q[$];
  logic       rx_p_q[$];
  logic       rx_st_q[$];
  int         rx_t_q[$];

  // Line monitor: mid-bit sampling of the selected DUT's serial line.
  initial begin : mon
    logic       prev;
    logic [7:0] b;
    logic       p, st;
    int         t;
    prev = 1'b1;
    forever begin
      @(negedge sys_clk);
      if (prev && !m_tx) begin
        t = cyc;
        p = 1'b0;
        repeat (mbaud / 2) @(negedge sys_clk);
        for (int k = 0; k < 8; k++) begin
          repeat (mbaud) @(negedge sys_clk);
          b[k] = m_tx;
        end
        if (mpar) begin
          repeat (mbaud) @(negedge sys_clk);
          p = m_tx;
        end
        repeat (mbaud) @(negedge sys_clk);
        st = m_tx;
        rx_q.push_back(b);
        rx_p_q.push_back(p);
        rx_st_q.push_back(st);
        rx_t_q.push_back(t);
      end
      prev = m_tx;
    end
  end

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic use_dut(input int s);
    sel   = s;
    mbaud = (s == 0) ? 434 : 4;
    mpar  = (s == 1);
  endtask

  task automatic flush();
    exp_q.delete(); rx_q.delete(); rx_p_q.delete(); rx_st_q.delete(); rx_t_q.delete();
  endtask

  int t_go;
  task automatic pulse_go();
    @(negedge sys_clk);
    go_v = 1'b1;
    @(negedge sys_clk);
    go_v = 1'b0;
    t_go = cyc - 1;
  endtask

  int busy_n, bd_n, done_n, done_dt, done_bdn;
  task automatic wait_xfer(input int budget);
    bit seen;
    seen = 1'b0; busy_n = 0; bd_n = 0; done_n = 0; done_dt = -1; done_bdn = -1;
    for (int i = 0; i < budget; i++) begin
      if (m_busy) begin
        seen = 1'b1;
        busy_n++;
      end else if (seen) begin
        break;
      end
      if (m_bd) bd_n++;
      if (m_done) begin
        done_n++;
        done_dt  = cyc - t_go;
        done_bdn = m_bd ? bd_n : -1;
      end
      @(negedge sys_clk);
    end
    chk("xfer_complete", {63'd0, seen && !m_busy}, 64'd1);
  endtask

  task automatic check_rx(input string tag);
    logic [7:0] e, r;
    logic       st;
    chk({tag, "_count"}, rx_q.size(), exp_q.size());
    for (int i = 0; exp_q.size() > 0 && rx_q.size() > 0; i++) begin
      e  = exp_q.pop_front();
      r  = rx_q.pop_front();
      st = rx_st_q.pop_front();
      chk($sformatf("%s_byte%0d", tag, i), r, e);
      chk($sformatf("%s_stop%0d", tag, i), st, 1);
    end
    flush();
  endtask

  task automatic chk_idle(input string tag);
    chk({tag, "_tx"}, m_tx, 1);
    chk({tag, "_busy"}, m_busy, 0);
    chk({tag, "_bd"}, m_bd, 0);
    chk({tag, "_done"}, m_done, 0);
  endtask

  initial begin
    int d0;
    // Reset state of every configuration
    repeat (3) @(negedge sys_clk);
    for (int s = 0; s < 4; s++) begin
      use_dut(s);
      #1 chk_idle($sformatf("rst%0d", s));
    end
    rst_n = 1'b1;
    repeat (2) @(negedge sys_clk);

    // Defaults: 5 bytes at 434 clocks per bit
    use_dut(0);
    chk_idle("idle0");
    data_v = 40'h1008040201; len_v = 3'd0;
    exp_q = '{8'h01, 8'h02, 8'h04, 8'h08, 8'h10};
    pulse_go();
    wait_xfer(30000);
    chk("def_busy_cycles", busy_n, 21700);
    chk("def_byte_done", bd_n, 5);
    chk("def_done_count", done_n, 1);
    chk("def_done_with_bd5", done_bdn, 5);
    chk("def_done_cycle", done_dt, 21700);
    if (rx_t_q.size() >= 2) begin
      chk("def_first_start", rx_t_q[0], t_go + 1);
      chk("def_byte_period", rx_t_q[1] - rx_t_q[0], 4340);
    end
    check_rx("def");

    // Even parity, BAUD_DIV=4
    use_dut(1);
    data_v = 40'h07; len_v = 3'd1;
    exp_q = '{8'h07};
    pulse_go();
    wait_xfer(200);
    chk("par_done_cycle", done_dt, 44);
    chk("par_busy", busy_n, 44);
    if (rx_p_q.size() > 0) chk("par_bit_07", rx_p_q[0], 1);
    check_rx("par07");
    data_v = 40'h03;
    exp_q = '{8'h03};
    pulse_go();
    wait_xfer(200);
    if (rx_p_q.size() > 0) chk("par_bit_03", rx_p_q[0], 0);
    check_rx("par03");

    // Two stop bits plus one gap bit
    use_dut(2);
    data_v = 40'h3CA5; len_v = 3'd2;
    exp_q = '{8'hA5, 8'h3C};
    pulse_go();
    wait_xfer(300);
    chk("gap_busy", busy_n, 92);
    chk("gap_bd", bd_n, 2);
    if (rx_t_q.size() >= 2) chk("gap_start_spacing", rx_t_q[1] - rx_t_q[0], 48);
    check_rx("gap");

    // Ignored trans_go mid-transfer and in the done cycle; accepted one later
    use_dut(3);
    data_v = 40'h2211; len_v = 3'd2;
    exp_q = '{8'h11, 8'h22};
    pulse_go();
    repeat (20) @(negedge sys_clk);
    data_v = 40'hFFFFFFFFFF; len_v = 3'd1; go_v = 1'b1;
    @(negedge sys_clk);
    go_v = 1'b0;
    for (int i = 0; i < 200 && !m_done; i++) @(negedge sys_clk);
    chk("b2b_done_seen", m_done, 1);
    data_v = 40'h99; go_v = 1'b1;
    @(negedge sys_clk);
    chk("b2b_idle_after_done", m_busy, 0);
    data_v = 40'h5A;
    @(negedge sys_clk);
    go_v = 1'b0;
    t_go = cyc - 1;
    chk("b2b_start_tx", m_tx, 0);
    chk("b2b_start_busy", m_busy, 1);
    exp_q.push_back(8'h5A);
    wait_xfer(200);
    check_rx("b2b");

    // Asynchronous reset during data bit 3
    data_v = 40'h00; len_v = 3'd1;
    d0 = done3_cnt;
    pulse_go();
    repeat (17) @(negedge sys_clk);
    chk("rst_pre_tx", m_tx, 0);
    #2 rst_n = 1'b0;
    #1;
    chk("rst_async_tx", m_tx, 1);
    chk("rst_async_busy", m_busy, 0);
    repeat (50) @(negedge sys_clk);
    chk("rst_no_done", done3_cnt, d0);
    flush();
    rst_n = 1'b1;
    repeat (2) @(negedge sys_clk);
    chk_idle("rst_release");
    data_v = 40'h44C3; len_v = 3'd2;
    exp_q = '{8'hC3, 8'h44};
    pulse_go();
    wait_xfer(300);
    check_rx("post_rst");

    // Length clamping and partial lengths
    data_v = 40'h5544332211; len_v = 3'd7;
    exp_q = '{8'h11, 8'h22, 8'h33, 8'h44, 8'h55};
    pulse_go();
    wait_xfer(400);
    chk("len7_bd", bd_n, 5);
    check_rx("len7");
    data_v = 40'hEEDDCCBBAA; len_v = 3'd3;
    exp_q = '{8'hAA, 8'hBB, 8'hCC};
    pulse_go();
    wait_xfer(400);
    chk("len3_bd", bd_n, 3);
    chk("len3_busy", busy_n, 120);
    repeat (100) @(negedge sys_clk);
    check_rx("len3");

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
